// File: rtl/layer_argmax_16.sv
// Streaming argmax over M signed words per vector; one registered result beat
// per vector with first-index-wins tie breaking.
module layer_argmax_16 #(
  parameter int M    = 16,
  parameter int T    = 16,
  parameter int LOGM = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [T-1:0]    data_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [LOGM-1:0] idx_out,
  output logic [T-1:0]    max_out
);

  typedef enum logic {ACC, OUT} state_t;

  state_t          state_q;
  logic [LOGM:0]   cnt_q;
  logic [T-1:0]    max_q;
  logic [LOGM-1:0] idx_q;

  logic            accept;
  logic            lastWord;
  logic            takeNew;
  logic [T-1:0]    max_d;
  logic [LOGM-1:0] idx_d;

  assign m_valid  = (state_q == OUT);
  assign s_ready  = reset && (!m_valid || m_ready);
  assign accept   = s_valid && s_ready;
  assign lastWord = (cnt_q == (LOGM+1)'(M-1));

  // Word 0 always loads; later words must be strictly greater so ties keep the earlier index.
  assign takeNew = (cnt_q == '0) || ($signed(data_in) > $signed(max_q));

  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (takeNew) begin
      max_d = data_in;
      idx_d = cnt_q[LOGM-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACC;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      idx_out <= '0;
      max_out <= '0;
    end else begin
      if (accept) begin
        max_q <= max_d;
        idx_q <= idx_d;
        cnt_q <= lastWord ? '0 : cnt_q + (LOGM+1)'(1);
      end
      // A completing word may land on the same edge the previous result drains.
      if (accept && lastWord) begin
        state_q <= OUT;
        idx_out <= idx_d;
        max_out <= max_d;
      end else if (m_valid && m_ready) begin
        state_q <= ACC;
      end
    end
  end

endmodule

// File: tb/tb_layer_argmax_16.sv
// Directed vector table plus hand sequences and a randomized scoreboard run
// for the streaming argmax block.
module tb_layer_argmax_16;

  localparam int M    = 16;
  localparam int T    = 16;
  localparam int LOGM = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic [T-1:0]    data_in;
  logic            m_valid;
  logic            m_ready;
  logic [LOGM-1:0] idx_out;
  logic [T-1:0]    max_out;

  typedef struct {
    logic signed [T-1:0] words [M];
    int                  expIdx;
    int                  expMax;
  } vecRec_t;

  vecRec_t tbl [4];
  int      testsRun    = 0;
  int      testsFailed = 0;
  int      stalls      = 0;
  int      beatsSeen   = 0;
  bit      monOn       = 1'b0;
  int      expIdxQ [$];
  int      expMaxQ [$];

  always #5 clk = ~clk;

  layer_argmax_16 #(.M(M), .T(T)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idx_out (idx_out),
    .max_out (max_out)
  );

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Holds s_valid high until the word is taken; s_valid stays high afterwards.
  task automatic applyStimulus(input logic signed [T-1:0] d);
    int waited = 0;
    s_valid = 1'b1;
    data_in = d;
    #1;
    while (!s_ready && waited < 200) begin
      tick;
      #1;
      waited++;
    end
    stalls += waited;
    if (!s_ready) checkOutput("acceptTimeout", s_ready, 1);
    @(posedge clk);
    #2;
  endtask

  // Result beats are consumed on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (monOn && m_valid && m_ready) begin
      if (expIdxQ.size() == 0) begin
        checkOutput("unexpectedResult", expIdxQ.size(), 1);
      end else begin
        checkOutput("randIdx", idx_out, expIdxQ.pop_front());
        checkOutput("randMax", $signed(max_out), expMaxQ.pop_front());
      end
      beatsSeen++;
    end
  end

  initial begin
    int stallsBefore;
    logic signed [T-1:0] rw [M];
    int bestIdx;
    int bestVal;
    bit accepted;
    int guard;

    for (int k = 0; k < M; k++) begin
      tbl[0].words[k] = '0;
      tbl[1].words[k] = -16'sd1;
      tbl[2].words[k] = 16'sd10;
      tbl[3].words[k] = 16'(k * 5);
    end
    tbl[0].words[1] = 16'sd5;  tbl[0].words[2] = 16'sd3; tbl[0].words[3] = 16'sd9;
    tbl[0].words[4] = 16'sd2;  tbl[0].words[5] = 16'sd9;
    tbl[0].expIdx = 3;  tbl[0].expMax = 9;
    tbl[1].words[12] = -16'sd7; tbl[1].words[15] = 16'sd0;
    tbl[1].expIdx = 15; tbl[1].expMax = 0;
    tbl[2].words[2] = 16'sd40;  tbl[2].words[9] = 16'sd40;
    tbl[2].expIdx = 2;  tbl[2].expMax = 40;
    tbl[3].words[14] = 16'sd120; tbl[3].words[15] = 16'sd115;
    tbl[3].expIdx = 14; tbl[3].expMax = 120;

    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = '0;
    #3;
    checkOutput("rstSready", s_ready, 0);
    checkOutput("rstMvalid", m_valid, 0);
    checkOutput("rstIdx", idx_out, 0);
    checkOutput("rstMax", $signed(max_out), 0);
    tick;
    tick;
    reset = 1'b1;

    // Table vectors; 2 and 3 stream back-to-back with no gap.
    m_ready = 1'b1;
    stallsBefore = stalls;
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < M; w++) begin
        applyStimulus(tbl[i].words[w]);
        if (i == 3 && w == 0) checkOutput("b2bDrain", m_valid, 0);
      end
      checkOutput($sformatf("vec%0dValid", i), m_valid, 1);
      checkOutput($sformatf("vec%0dIdx", i), idx_out, tbl[i].expIdx);
      checkOutput($sformatf("vec%0dMax", i), $signed(max_out), tbl[i].expMax);
      if (i != 2) begin
        s_valid = 1'b0;
        tick;
        checkOutput($sformatf("vec%0dOneCycle", i), m_valid, 0);
      end
    end
    checkOutput("noBubble", stalls - stallsBefore, 0);

    // Back-pressure: result held while the next word waits.
    m_ready = 1'b0;
    for (int w = 0; w < M; w++) applyStimulus((w == 7) ? 16'sd100 : 16'(w * 3));
    s_valid = 1'b1;
    data_in = 16'sd55;
    for (int c = 0; c < 10; c++) begin
      #1;
      checkOutput("bpSready", s_ready, 0);
      checkOutput("bpValid", m_valid, 1);
      checkOutput("bpIdx", idx_out, 7);
      checkOutput("bpMax", $signed(max_out), 100);
      tick;
    end
    m_ready = 1'b1;
    #1;
    checkOutput("bpDrainSready", s_ready, 1);
    @(posedge clk);
    #2;
    checkOutput("bpDrained", m_valid, 0);
    for (int w = 1; w < M; w++) applyStimulus(16'sd1);
    checkOutput("bpNextIdx", idx_out, 0);
    checkOutput("bpNextMax", $signed(max_out), 55);

    // Reset mid-vector discards the partial vector containing 500.
    for (int w = 0; w < 6; w++) applyStimulus((w == 4) ? 16'sd500 : 16'(w + 1));
    s_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midRstSready", s_ready, 0);
    checkOutput("midRstValid", m_valid, 0);
    checkOutput("midRstIdx", idx_out, 0);
    checkOutput("midRstMax", $signed(max_out), 0);
    tick;
    tick;
    reset = 1'b1;
    for (int w = 0; w < M; w++)
      applyStimulus((w == 0) ? 16'sd3 : (w == 1) ? 16'sd20 : 16'(w - 4));
    checkOutput("postRstIdx", idx_out, 1);
    checkOutput("postRstMax", $signed(max_out), 20);
    s_valid = 1'b0;
    tick;
    checkOutput("postRstDrained", m_valid, 0);

    // Randomized vectors with random gaps on both handshakes.
    monOn = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      for (int w = 0; w < M; w++) begin
        if (v % 2 == 0) rw[w] = 16'($urandom_range(0, 8)) - 16'sd4;
        else            rw[w] = 16'($urandom);
      end
      bestIdx = 0;
      bestVal = rw[0];
      for (int w = 1; w < M; w++) begin
        if (int'(rw[w]) > bestVal) begin
          bestVal = rw[w];
          bestIdx = w;
        end
      end
      expIdxQ.push_back(bestIdx);
      expMaxQ.push_back(bestVal);
      for (int w = 0; w < M; w++) begin
        accepted = 1'b0;
        guard = 0;
        while (!accepted && guard < 1000) begin
          m_ready = ($urandom_range(0, 3) != 0);
          s_valid = ($urandom_range(0, 3) != 0);
          data_in = s_valid ? rw[w] : 16'($urandom);
          #1;
          accepted = s_valid && s_ready;
          @(posedge clk);
          #2;
          guard++;
        end
        if (!accepted) checkOutput("randAcceptTimeout", accepted, 1);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    guard = 0;
    while (expIdxQ.size() != 0 && guard < 100) begin
      tick;
      guard++;
    end
    tick;
    monOn = 1'b0;
    checkOutput("randQueueEmpty", expIdxQ.size(), 0);
    checkOutput("randBeats", beatsSeen, 1000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
